// File: rtl/cpu_icache_if.sv
// cpu_icache_if: fetch-to-Icache lookup bundle.
//   master (fetch): drives en_rx/en_ry read requests and word-aligned PCs pcx/pcy.
//   slave  (cache): returns hitx/hity flags and instruction words instx/insty.
// The cache answers combinationally, so fetch may sample on the negedge of
// the same cycle in which it presented the request.
interface cpu_icache_if #(
    parameter int ADDR_W = 32
);
    logic              en_rx;
    logic              en_ry;
    logic [ADDR_W-1:0] pcx;
    logic [ADDR_W-1:0] pcy;
    logic              hitx;
    logic              hity;
    logic [31:0]       instx;
    logic [31:0]       insty;

    modport master (
        output en_rx, en_ry, pcx, pcy,
        input  hitx, hity, instx, insty
    );

    modport slave (
        input  en_rx, en_ry, pcx, pcy,
        output hitx, hity, instx, insty
    );
endinterface

// File: rtl/cpu_icache.sv
// cpu_icache: dual-read-port, direct-mapped instruction cache, one 32-bit
// word per line, refilled byte-serially from a byte-wide arbitrated port.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   rdy        global ready; low freezes all state
//   fetch      cpu_icache_if.slave lookup bundle (two read ports X and Y)
//   mem_req    memory port request, held for the whole refill
//   mem_gnt    arbiter grant
//   mem_a      byte read address
//   mem_din    read data, valid one cycle after mem_a is presented
//   busy       refill in progress
// A line holds {B(a), B(a+1), B(a+2), B(a+3)} with B(a) in [31:24].
module cpu_icache #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    cpu_icache_if.slave       fetch,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [7:0]        mem_din,
    output logic              busy
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   miss_addr;
    logic [2:0]          ic;
    logic [2:0]          rc;
    logic [31:0]         fill_buf;
    logic [ADDR_W-1:0]   mem_a_q;

    logic [31:0]         data_mem [LINES];
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [LINES-1:0]    valid;

    logic [INDEX_BITS-1:0] ix, iy, widx;
    logic [TAG_W-1:0]      tagx, tagy;
    logic                  hit_x, hit_y;
    logic                  miss_x, miss_y;
    logic [ADDR_W-1:0]     fill_addr;
    logic                  in_flight;
    logic                  issue;
    logic                  capture;

    assign ix   = fetch.pcx[INDEX_BITS+1:2];
    assign iy   = fetch.pcy[INDEX_BITS+1:2];
    assign tagx = fetch.pcx[ADDR_W-1:INDEX_BITS+2];
    assign tagy = fetch.pcy[ADDR_W-1:INDEX_BITS+2];
    assign widx = miss_addr[INDEX_BITS+1:2];

    assign hit_x  = fetch.en_rx & valid[ix] & (tag_mem[ix] == tagx);
    assign hit_y  = fetch.en_ry & valid[iy] & (tag_mem[iy] == tagy);
    assign miss_x = fetch.en_rx & ~hit_x;
    assign miss_y = fetch.en_ry & ~hit_y;

    // Port X wins when both ports miss in the same cycle.
    assign fill_addr = miss_x ? fetch.pcx : fetch.pcy;

    // Issue and receive counts differ by exactly one while a byte is in flight.
    assign in_flight = (ic != rc);
    assign issue     = rdy & ~rst & (state == FILL) & mem_gnt & ~ic[2];
    assign capture   = rdy & (state == FILL) & mem_gnt & in_flight;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (miss_x | miss_y) state_n = REQ;
            REQ:     if (mem_gnt) state_n = FILL;
            FILL:    if (capture && rc == 3'd3) state_n = WRITE;
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs. While nothing is being issued mem_a keeps the last issued
    // address, so a byte lost to an rdy=0 stall is simply read again from the
    // same address and arrives in the first cycle after rdy returns.
    always_comb begin
        fetch.hitx  = hit_x;
        fetch.hity  = hit_y;
        fetch.instx = hit_x ? data_mem[ix] : 32'h0;
        fetch.insty = hit_y ? data_mem[iy] : 32'h0;
        mem_req     = (state != IDLE);
        busy        = (state != IDLE);
        mem_a       = issue ? (miss_addr + ADDR_W'(ic)) : mem_a_q;
    end

    // Refill datapath. A grant drop discards the in-flight byte by pulling
    // the issue count back to the receive count.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr <= '0;
            ic        <= '0;
            rc        <= '0;
            fill_buf  <= '0;
            mem_a_q   <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (miss_x | miss_y)
                        miss_addr <= fill_addr;
                end
                REQ: begin
                    if (mem_gnt) begin
                        ic <= '0;
                        rc <= '0;
                    end
                end
                FILL: begin
                    if (!mem_gnt) begin
                        ic <= rc;
                    end else begin
                        if (issue) begin
                            ic      <= ic + 3'd1;
                            mem_a_q <= miss_addr + ADDR_W'(ic);
                        end
                        if (capture) begin
                            case (rc[1:0])
                                2'd0:    fill_buf[31:24] <= mem_din;
                                2'd1:    fill_buf[23:16] <= mem_din;
                                2'd2:    fill_buf[15:8]  <= mem_din;
                                default: fill_buf[7:0]   <= mem_din;
                            endcase
                            rc <= rc + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid bits are the only array state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (rdy && state == WRITE)
            valid[widx] <= 1'b1;
    end

    // Line install; a reset landing on WRITE abandons the fill.
    always_ff @(posedge clk) begin
        if (!rst && rdy && state == WRITE) begin
            data_mem[widx] <= fill_buf;
            tag_mem[widx]  <= miss_addr[ADDR_W-1:INDEX_BITS+2];
        end
    end
endmodule
